// File: rtl/reg_file_bank.sv
// Parametrised register file with range-checked ports, optional hardwired zero entry and a
// one-entry-per-cycle bulk-clear engine. Define REG_FILE_BYPASS_EN to forward accepted writes to reads.
module reg_file_bank #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic              Reg_File_Bank_CLK,
    input  logic              Reg_File_Bank_RST,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic [ADDR_W-1:0] A3,
    input  logic              WE3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              CLR_REQ,
    output logic              CLR_BUSY,
    output logic              CLR_DONE,
    output logic              WR_ERR
);

    // state | meaning
    // IDLE  | normal operation, waiting for CLR_REQ
    // CLEAR | zeroing entry[clr_cnt] each edge, writes dropped
    // DONE  | clear finished, CLR_DONE pulse, writes still dropped
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    localparam int                CNT_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DEPTH - 1);

    state_t            state;
    logic [CNT_W-1:0]  clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic a1_ok;
    logic a2_ok;
    logic a3_ok;
    logic wr_ok;
    logic wr_busy_drop;
    logic [DATA_W-1:0] rd1_arr;
    logic [DATA_W-1:0] rd2_arr;

    // Address is usable when it is implemented and is not the hardwired zero entry.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_A) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign a1_ok        = addr_ok(A1);
    assign a2_ok        = addr_ok(A2);
    assign a3_ok        = addr_ok(A3);
    assign wr_ok        = WE3 && a3_ok && !CLR_BUSY;
    assign wr_busy_drop = WE3 && a3_ok && CLR_BUSY;

    assign rd1_arr = a1_ok ? mem[A1] : '0;
    assign rd2_arr = a2_ok ? mem[A2] : '0;

`ifdef REG_FILE_BYPASS_EN
    always_comb begin
        RD1 = rd1_arr;
        RD2 = rd2_arr;
        if (wr_ok && (A1 == A3)) RD1 = WD3;
        if (wr_ok && (A2 == A3)) RD2 = WD3;
    end
`else
    always_comb begin
        RD1 = rd1_arr;
        RD2 = rd2_arr;
    end
`endif

    always_ff @(posedge Reg_File_Bank_CLK or negedge Reg_File_Bank_RST) begin
        if (!Reg_File_Bank_RST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            state    <= IDLE;
            clr_cnt  <= '0;
            CLR_BUSY <= 1'b0;
            CLR_DONE <= 1'b0;
            WR_ERR   <= 1'b0;
        end else begin
            WR_ERR <= wr_busy_drop;
            if (wr_ok) mem[A3] <= WD3;
            case (state)
                IDLE: begin
                    if (CLR_REQ) begin
                        state    <= CLEAR;
                        clr_cnt  <= '0;
                        CLR_BUSY <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[clr_cnt] <= '0;
                    // Counter parks at the last index rather than wrapping.
                    if (clr_cnt == LAST) begin
                        state    <= DONE;
                        CLR_DONE <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    CLR_BUSY <= 1'b0;
                    CLR_DONE <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    CLR_BUSY <= 1'b0;
                    CLR_DONE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_file_bank.md
# reg_file_bank

Parametrised successor to the MIPS core register file: configurable data width, address width and depth, with optional hardwired-zero register, range-checked addressing, and a sequential bulk-clear engine that zeroes the array one entry per cycle on request. It sits in the decode stage, feeding operand reads to the ALU path and accepting writeback from the final stage. An optional write-to-read bypass is selected at compile time.

## Interface

Parameters:
- DATA_W, 32, data width of each entry.
- ADDR_W, 5, address width of A1/A2/A3.
- DEPTH, 32, number of implemented entries; must satisfy 2 ≤ DEPTH ≤ 2^ADDR_W.
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register.

Ports:
- Reg_File_Bank_CLK in 1: single clock, rising edge.
- Reg_File_Bank_RST in 1: reset, asynchronous, active-low.
- A1 in ADDR_W: read address, port 1.
- A2 in ADDR_W: read address, port 2.
- RD1 out DATA_W: read data, port 1, combinational.
- RD2 out DATA_W: read data, port 2, combinational.
- A3 in ADDR_W: write address.
- WE3 in 1: write enable.
- WD3 in DATA_W: write data.
- CLR_REQ in 1: bulk-clear request, sampled on the clock edge.
- CLR_BUSY out 1: clear engine active; registered.
- CLR_DONE out 1: one-cycle pulse when clear completes; registered.
- WR_ERR out 1: one-cycle pulse, the cycle after a write was dropped because CLR_BUSY was high; registered.

## Operation

- Reset (async, RST low): all DEPTH entries = 0, FSM = IDLE, clear counter = 0, CLR_BUSY = 0, CLR_DONE = 0, WR_ERR = 0. RD1/RD2 then read 0.
- Read: RDn = entry[An] when An < DEPTH and not (ZERO_REG=1 and An=0); otherwise 0.
- Write is accepted at the rising edge when WE3=1, A3 < DEPTH, not (ZERO_REG=1 and A3=0), and CLR_BUSY=0. All other writes are discarded. Out-of-range and zero-register writes are discarded silently. A write discarded only because CLR_BUSY=1 sets WR_ERR=1 for the next cycle.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: CLR_REQ=1 at an edge → CLEAR, counter := 0, CLR_BUSY := 1.
  - CLEAR: each edge zeroes entry[counter], counter++. The edge that clears entry DEPTH-1 → DONE, CLR_DONE := 1.
  - DONE: the next edge → IDLE, CLR_BUSY := 0, CLR_DONE := 0.
- CLR_REQ is ignored while in CLEAR or DONE; requests are not queued.
- During CLEAR, reads return live array contents. Entries below the counter read 0; entries at or above it read their old values.

## Timing

- Read latency is 0 cycles (combinational from An and array state).
- Write latency is 1 edge. A read of the same address in the same cycle returns the old value unless REG_FILE_BYPASS_EN is defined.
- CLR_REQ sampled at edge k:
  - CLR_BUSY is high from after edge k to after edge k+DEPTH+1, i.e. DEPTH+1 cycles.
  - CLR_DONE is high for exactly the one cycle after edge k+DEPTH.
- CLR_REQ and an accepted WE3 at the same IDLE edge: the write commits at that edge, and the clear later overwrites it with 0.
- Reset asserted mid-clear: immediate return to the reset state. The clear is abandoned, and because reset zeroes every entry, the array ends up fully cleared.
- Counter width is clog2(DEPTH). The counter never wraps: the FSM leaves CLEAR at DEPTH-1.

## Configuration

- REG_FILE_BYPASS_EN defined:
  - RD1 = WD3 when WE3=1 and A1=A3 and the write would be accepted this cycle; otherwise the normal read.
  - RD2 follows the same rule with A2.
  - Bypass never applies to dropped writes: zero register, out-of-range, or CLR_BUSY.
- REG_FILE_BYPASS_EN undefined: no forwarding; reads reflect only committed array state.

## Test plan

- Reset, then with WE3=1, A3=5, WD3=0xDEADBEEF for one edge → next cycle A1=5 gives RD1=0xDEADBEEF; A2=6 gives RD2=0.
- ZERO_REG=1: write A3=0, WD3=0x1234 → A1=0 gives RD1=0. Out-of-range write with DEPTH=24, A3=30 → RD1 at A1=30 is 0, and WR_ERR stays 0.
- DEPTH=32: fill all entries with index+1, pulse CLR_REQ at edge k → CLR_BUSY high for 33 cycles; CLR_DONE high exactly the cycle after edge k+32; after the clear, all reads return 0; mid-clear at counter=10, entry 9 reads 0 and entry 10 reads 11.
- During CLR_BUSY, WE3=1, A3=3, WD3=0x55 → entry 3 ends at 0, WR_ERR=1 for one cycle; a second CLR_REQ in this window is ignored, with no extra CLR_DONE.
- Assert reset while the clear counter is at 7 → CLR_BUSY=0, CLR_DONE=0, all entries 0 immediately; after release, the FSM is in IDLE.
- With REG_FILE_BYPASS_EN: WE3=1, A3=A1=9, WD3=0xA5A5A5A5 → RD1=0xA5A5A5A5 in the same cycle. With the macro undefined, RD1 = old value in that cycle and 0xA5A5A5A5 after the edge.
